multi_color_corner_detect: RTL and testbench

Parametrised multi-channel successor to the single-colour corner detector in the VGA vision path. It sits between the per-pixel colour classifier/median filter and the SRAM history write-back. It tracks NUM_COLORS independent colour channels, each with configurable-depth temporal history and per-channel threshold. Per channel and per frame it finds the four extreme points (left, top, bottom, right) and a hit count, and tags each streamed pixel against the previous frame's corners.

---
 rtl/multi_color_pkg.sv | 34 +++
 rtl/color_channel_tracker.sv | 136 +++++++++++++
 rtl/multi_color_corner_detect.sv | 211 +++++++++++++++++++++
 tb/tb_multi_color_corner_detect.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_color_pkg.sv
// Shared codes and width helpers for the multi-colour corner detector.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package multi_color_pkg;

  // Per-pixel classification codes driven on out_class.
  typedef enum logic [2:0] {
    CLS_NONE         = 3'd0,
    CLS_TOP_LEFT     = 3'd1,
    CLS_TOP_RIGHT    = 3'd2,
    CLS_BOTTOM_LEFT  = 3'd3,
    CLS_BOTTOM_RIGHT = 3'd4,
    CLS_HIT          = 3'd5
  } out_class_e;

  // Corner index used both for the read port and the packed corner vectors.
  typedef enum logic [1:0] {
    SEL_TL = 2'd0,
    SEL_TR = 2'd1,
    SEL_BL = 2'd2,
    SEL_BR = 2'd3
  } corner_sel_e;

  // Channel id width; never below one bit so a 1-channel id port stays legal.
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Width able to hold a popcount of 0..depth.
  function automatic int th_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/color_channel_tracker.sv
// One colour channel: hit decision plus per-frame extreme-point and hit-count tracking.
// Latency: hit is combinational; corner/count state updates on the clock edge, prev set after a boundary.
// Backpressure: none; accepts one pixel per clock.
// Ports: clk/reset; boundary (frame edge this cycle); stat_en (valid, in-range pixel);
//   match/history/threshold (channel inputs); x/y (pixel location);
//   hit (combinational); prev_cx/prev_cy (4 corners packed by corner_sel_e); prev_count.
module color_channel_tracker
  import multi_color_pkg::*;
#(
  parameter int HIST_DEPTH = 4,
  parameter int TH_W       = 3,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int CNT_W      = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  boundary,
  input  logic                  stat_en,
  input  logic                  match,
  input  logic [HIST_DEPTH-1:0] history,
  input  logic [TH_W-1:0]       threshold,
  input  logic [X_W-1:0]        x,
  input  logic [Y_W-1:0]        y,
  output logic                  hit,
  output logic [4*X_W-1:0]      prev_cx,
  output logic [4*Y_W-1:0]      prev_cy,
  output logic [CNT_W-1:0]      prev_count
);

  localparam logic [X_W-1:0]   X_MIN_INIT = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]   Y_MIN_INIT = Y_W'(V_RES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [TH_W-1:0] ones;

  always_comb begin
    ones = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      ones = ones + TH_W'(history[i]);
    end
  end

  assign hit = match && (ones > threshold);

  logic [X_W-1:0]          x_max_q, x_max_d, x_min_q, x_min_d;
  logic [Y_W-1:0]          y_max_q, y_max_d, y_min_q, y_min_d;
  logic [3:0][X_W-1:0]     cx_q, cx_d, pcx_q, pcx_d;
  logic [3:0][Y_W-1:0]     cy_q, cy_d, pcy_q, pcy_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, pcnt_q, pcnt_d;

  always_comb begin
    x_max_d = x_max_q;
    x_min_d = x_min_q;
    y_max_d = y_max_q;
    y_min_d = y_min_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    pcx_d   = pcx_q;
    pcy_d   = pcy_q;
    pcnt_d  = pcnt_q;

    if (boundary) begin
      // Publish the finished frame and restart; a pixel in this cycle is not counted.
      pcx_d   = cx_q;
      pcy_d   = cy_q;
      pcnt_d  = cnt_q;
      x_max_d = '0;
      x_min_d = X_MIN_INIT;
      y_max_d = '0;
      y_min_d = Y_MIN_INIT;
      cx_d    = '0;
      cy_d    = '0;
      cnt_d   = '0;
    end else if (stat_en && hit) begin
      // Non-strict compares so that ties move the corner to the later pixel.
      if (x >= x_max_q) begin
        x_max_d      = x;
        cx_d[SEL_BR] = x;
        cy_d[SEL_BR] = y;
      end
      if (x <= x_min_q) begin
        x_min_d      = x;
        cx_d[SEL_TL] = x;
        cy_d[SEL_TL] = y;
      end
      if (y >= y_max_q) begin
        y_max_d      = y;
        cx_d[SEL_BL] = x;
        cy_d[SEL_BL] = y;
      end
      if (y <= y_min_q) begin
        y_min_d      = y;
        cx_d[SEL_TR] = x;
        cy_d[SEL_TR] = y;
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_max_q <= '0;
      x_min_q <= X_MIN_INIT;
      y_max_q <= '0;
      y_min_q <= Y_MIN_INIT;
      cx_q    <= '0;
      cy_q    <= '0;
      cnt_q   <= '0;
      pcx_q   <= '0;
      pcy_q   <= '0;
      pcnt_q  <= '0;
    end else begin
      x_max_q <= x_max_d;
      x_min_q <= x_min_d;
      y_max_q <= y_max_d;
      y_min_q <= y_min_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      pcx_q   <= pcx_d;
      pcy_q   <= pcy_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign prev_cx    = pcx_q;
  assign prev_cy    = pcy_q;
  assign prev_count = pcnt_q;

endmodule

// File: rtl/multi_color_corner_detect.sv
// Multi-channel corner detector: per-channel temporal history, extreme points, pixel tagging.
// Latency: 1 cycle input to all registered outputs; corner_x/corner_y are combinational.
// Backpressure: none; one pixel per clock, out_valid/we simply follow in_valid.
// Ports: VGA_VS (falling edge = frame boundary); in_valid + colour/history/threshold/location inputs;
//   registered pixel outputs (out_valid, we, write_addr, color_x/y, updated_color_history,
//   out_color_id, out_class); corner read port (corner_sel_ch/corner_sel -> corner_x/y);
//   prev_count per channel; frame_done pulse.
module multi_color_corner_detect
  import multi_color_pkg::*;
#(
  parameter int NUM_COLORS = 2,
  parameter int HIST_DEPTH = 4,
  parameter int X_W        = 10,
  parameter int Y_W        = 10,
  parameter int ADDR_W     = 19,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int CNT_W      = 19,
  localparam int ID_W      = id_width(NUM_COLORS),
  localparam int TH_W      = th_width(HIST_DEPTH)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             VGA_VS,
  input  logic                             in_valid,
  input  logic [NUM_COLORS-1:0]            color_match,
  input  logic [NUM_COLORS*HIST_DEPTH-1:0] color_history,
  input  logic [NUM_COLORS*TH_W-1:0]       threshold,
  input  logic [ADDR_W-1:0]                read_addr,
  input  logic [X_W-1:0]                   read_x,
  input  logic [Y_W-1:0]                   read_y,
  output logic                             out_valid,
  output logic                             we,
  output logic [ADDR_W-1:0]                write_addr,
  output logic [X_W-1:0]                   color_x,
  output logic [Y_W-1:0]                   color_y,
  output logic [NUM_COLORS*HIST_DEPTH-1:0] updated_color_history,
  output logic [ID_W-1:0]                  out_color_id,
  output logic [2:0]                       out_class,
  input  logic [ID_W-1:0]                  corner_sel_ch,
  input  logic [1:0]                       corner_sel,
  output logic [X_W-1:0]                   corner_x,
  output logic [Y_W-1:0]                   corner_y,
  output logic [NUM_COLORS*CNT_W-1:0]      prev_count,
  output logic                             frame_done
);

  // One extra bit so a resolution equal to 2**X_W still compares correctly.
  localparam logic [X_W:0] X_LIM = (X_W + 1)'(H_RES);
  localparam logic [Y_W:0] Y_LIM = (Y_W + 1)'(V_RES);

  logic vs_q, vs_d;
  logic boundary, in_range, stat_en;

  assign boundary = vs_q & ~VGA_VS;
  assign in_range = ({1'b0, read_x} < X_LIM) && ({1'b0, read_y} < Y_LIM);
  assign stat_en  = in_valid & in_range;

  logic [NUM_COLORS-1:0]            hit_vec;
  logic [3:0][X_W-1:0]              prev_cx_all [NUM_COLORS];
  logic [3:0][Y_W-1:0]              prev_cy_all [NUM_COLORS];
  logic [NUM_COLORS*HIST_DEPTH-1:0] upd_hist;

  for (genvar g = 0; g < NUM_COLORS; g++) begin : g_ch
    color_channel_tracker #(
      .HIST_DEPTH (HIST_DEPTH),
      .TH_W       (TH_W),
      .X_W        (X_W),
      .Y_W        (Y_W),
      .H_RES      (H_RES),
      .V_RES      (V_RES),
      .CNT_W      (CNT_W)
    ) u_trk (
      .clk        (clk),
      .reset      (reset),
      .boundary   (boundary),
      .stat_en    (stat_en),
      .match      (color_match[g]),
      .history    (color_history[g*HIST_DEPTH +: HIST_DEPTH]),
      .threshold  (threshold[g*TH_W +: TH_W]),
      .x          (read_x),
      .y          (read_y),
      .hit        (hit_vec[g]),
      .prev_cx    (prev_cx_all[g]),
      .prev_cy    (prev_cy_all[g]),
      .prev_count (prev_count[g*CNT_W +: CNT_W])
    );

    // History shifts in the raw match bit regardless of whether the channel hit.
    assign upd_hist[g*HIST_DEPTH +: HIST_DEPTH] =
      {color_history[g*HIST_DEPTH +: HIST_DEPTH-1], color_match[g]};
  end

  logic [ID_W-1:0]     win_id;
  logic                any_hit;
  logic [3:0][X_W-1:0] win_cx;
  logic [3:0][Y_W-1:0] win_cy;
  out_class_e          cls;

  always_comb begin
    win_id  = '0;
    any_hit = 1'b0;
    // Descending scan leaves the lowest hitting index as the winner.
    for (int c = NUM_COLORS - 1; c >= 0; c--) begin
      if (hit_vec[c]) begin
        win_id  = ID_W'(c);
        any_hit = 1'b1;
      end
    end

    win_cx = '0;
    win_cy = '0;
    for (int c = 0; c < NUM_COLORS; c++) begin
      if (win_id == ID_W'(c)) begin
        win_cx = prev_cx_all[c];
        win_cy = prev_cy_all[c];
      end
    end

    if (!any_hit || !in_range) begin
      cls = CLS_NONE;
    end else if (read_x == win_cx[SEL_TL] && read_y == win_cy[SEL_TL]) begin
      cls = CLS_TOP_LEFT;
    end else if (read_x == win_cx[SEL_TR] && read_y == win_cy[SEL_TR]) begin
      cls = CLS_TOP_RIGHT;
    end else if (read_x == win_cx[SEL_BL] && read_y == win_cy[SEL_BL]) begin
      cls = CLS_BOTTOM_LEFT;
    end else if (read_x == win_cx[SEL_BR] && read_y == win_cy[SEL_BR]) begin
      cls = CLS_BOTTOM_RIGHT;
    end else begin
      cls = CLS_HIT;
    end
  end

  // Read port: an id beyond NUM_COLORS reads as zero.
  always_comb begin
    corner_x = '0;
    corner_y = '0;
    for (int c = 0; c < NUM_COLORS; c++) begin
      if (corner_sel_ch == ID_W'(c)) begin
        corner_x = prev_cx_all[c][corner_sel];
        corner_y = prev_cy_all[c][corner_sel];
      end
    end
  end

  logic                             out_valid_q, out_valid_d;
  logic                             frame_done_q, frame_done_d;
  logic [ADDR_W-1:0]                write_addr_q, write_addr_d;
  logic [X_W-1:0]                   color_x_q, color_x_d;
  logic [Y_W-1:0]                   color_y_q, color_y_d;
  logic [NUM_COLORS*HIST_DEPTH-1:0] hist_q, hist_d;
  logic [ID_W-1:0]                  color_id_q, color_id_d;
  logic [2:0]                       class_q, class_d;

  always_comb begin
    vs_d         = VGA_VS;
    out_valid_d  = in_valid;
    frame_done_d = boundary;
    write_addr_d = write_addr_q;
    color_x_d    = color_x_q;
    color_y_d    = color_y_q;
    hist_d       = hist_q;
    color_id_d   = color_id_q;
    class_d      = class_q;
    // Payload outputs hold through invalid cycles.
    if (in_valid) begin
      write_addr_d = read_addr;
      color_x_d    = read_x;
      color_y_d    = read_y;
      hist_d       = upd_hist;
      color_id_d   = win_id;
      class_d      = cls;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      write_addr_q <= '0;
      color_x_q    <= '0;
      color_y_q    <= '0;
      hist_q       <= '0;
      color_id_q   <= '0;
      class_q      <= '0;
    end else begin
      vs_q         <= vs_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
      write_addr_q <= write_addr_d;
      color_x_q    <= color_x_d;
      color_y_q    <= color_y_d;
      hist_q       <= hist_d;
      color_id_q   <= color_id_d;
      class_q      <= class_d;
    end
  end

  assign out_valid             = out_valid_q;
  assign we                    = out_valid_q;
  assign frame_done            = frame_done_q;
  assign write_addr            = write_addr_q;
  assign color_x               = color_x_q;
  assign color_y               = color_y_q;
  assign updated_color_history = hist_q;
  assign out_color_id          = color_id_q;
  assign out_class             = class_q;

endmodule

// File: tb/tb_multi_color_corner_detect.sv
// Self-checking bench for multi_color_corner_detect (2 channels, 4-deep history).
// The hit counter is narrowed to 6 bits so saturation is reached in a short frame.
module tb_multi_color_corner_detect;

  logic        clk = 1'b0;
  logic        rst;
  logic        VGA_VS;
  logic        in_valid;
  logic [1:0]  color_match;
  logic [7:0]  color_history;
  logic [5:0]  threshold;
  logic [18:0] read_addr;
  logic [9:0]  read_x;
  logic [9:0]  read_y;
  logic        out_valid;
  logic        we;
  logic [18:0] write_addr;
  logic [9:0]  color_x;
  logic [9:0]  color_y;
  logic [7:0]  updated_color_history;
  logic [0:0]  out_color_id;
  logic [2:0]  out_class;
  logic [0:0]  corner_sel_ch;
  logic [1:0]  corner_sel;
  logic [9:0]  corner_x;
  logic [9:0]  corner_y;
  logic [11:0] prev_count;
  logic        frame_done;

  always #5 clk = ~clk;

  multi_color_corner_detect #(
    .NUM_COLORS (2),
    .HIST_DEPTH (4),
    .CNT_W      (6)
  ) dut (
    .clk                   (clk),
    .reset                 (rst),
    .VGA_VS                (VGA_VS),
    .in_valid              (in_valid),
    .color_match           (color_match),
    .color_history         (color_history),
    .threshold             (threshold),
    .read_addr             (read_addr),
    .read_x                (read_x),
    .read_y                (read_y),
    .out_valid             (out_valid),
    .we                    (we),
    .write_addr            (write_addr),
    .color_x               (color_x),
    .color_y               (color_y),
    .updated_color_history (updated_color_history),
    .out_color_id          (out_color_id),
    .out_class             (out_class),
    .corner_sel_ch         (corner_sel_ch),
    .corner_sel            (corner_sel),
    .corner_x              (corner_x),
    .corner_y              (corner_y),
    .prev_count            (prev_count),
    .frame_done            (frame_done)
  );

  localparam logic [7:0] H_ALL = 8'hFF;
  localparam logic [5:0] TH1   = 6'b001_001;
  localparam logic [2:0] C_NONE = 3'd0, C_TL = 3'd1, C_TR = 3'd2, C_BL = 3'd3,
                         C_BR = 3'd4, C_HIT = 3'd5;

  typedef struct packed {
    logic [18:0] addr;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [7:0]  hist;
    logic        id;
    logic [2:0]  cls;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int vectors     = 0;
  int miscompares = 0;

  // Drive one valid pixel on the falling edge and queue its expected output.
  task automatic pix(input int x, input int y, input logic [1:0] m, input logic [7:0] h,
                     input logic [5:0] th, input logic exp_id, input logic [2:0] exp_cls);
    exp_t e;
    @(negedge clk);
    VGA_VS        = 1'b0;
    in_valid      = 1'b1;
    read_x        = 10'(x);
    read_y        = 10'(y);
    read_addr     = 19'(y * 640 + x);
    color_match   = m;
    color_history = h;
    threshold     = th;
    e.addr = 19'(y * 640 + x);
    e.x    = 10'(x);
    e.y    = 10'(y);
    e.hist = {h[6:4], m[1], h[2:0], m[0]};
    e.id   = exp_id;
    e.cls  = exp_cls;
    sbq.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // VS high for one cycle then low; returns just after the edge that registers the boundary.
  task automatic vs_edge();
    @(negedge clk);
    in_valid = 1'b0;
    VGA_VS   = 1'b1;
    @(negedge clk);
    VGA_VS   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: every registered output pixel is matched against the queue.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      vectors++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: out_valid=1 at x=%0d y=%0d, required no output", color_x, color_y);
      end else begin
        mon_e = sbq.pop_front();
        if ({we, write_addr, color_x, color_y, updated_color_history, out_color_id, out_class} !==
            {1'b1, mon_e.addr, mon_e.x, mon_e.y, mon_e.hist, mon_e.id, mon_e.cls}) begin
          miscompares++;
          $display("FAIL pixel(%0d,%0d): got we=%b addr=%0d x=%0d y=%0d hist=%h id=%0d cls=%0d, required we=1 addr=%0d x=%0d y=%0d hist=%h id=%0d cls=%0d",
                   mon_e.x, mon_e.y, we, write_addr, color_x, color_y, updated_color_history,
                   out_color_id, out_class, mon_e.addr, mon_e.x, mon_e.y, mon_e.hist, mon_e.id, mon_e.cls);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; VGA_VS = 1'b0; in_valid = 1'b0; color_match = '0; color_history = '0;
    threshold = '0; read_addr = '0; read_x = '0; read_y = '0; corner_sel_ch = '0; corner_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, we, frame_done, out_class, out_color_id, color_x, color_y, write_addr, updated_color_history} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b we=%b fd=%b cls=%0d id=%0d x=%0d y=%0d addr=%0d hist=%h, required all 0",
               out_valid, we, frame_done, out_class, out_color_id, color_x, color_y, write_addr, updated_color_history);
    end
    vectors++;
    if (prev_count !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_prev_count: got %h required 0", prev_count);
    end
    vectors++;
    if ({corner_x, corner_y} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_corner: got (%0d,%0d) required (0,0)", corner_x, corner_y);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_vs_low_not_edge: frame_done got %b required 0", frame_done);
    end
  endtask

  task automatic test_frame();
    logic [9:0] ex [4];
    logic [9:0] ey [4];
    ex = '{10'd10, 10'd300, 10'd50, 10'd600};
    ey = '{10'd20, 10'd5, 10'd470, 10'd400};
    pix(10, 20, 2'b01, H_ALL, TH1, 1'b0, C_HIT);
    pix(300, 5, 2'b01, H_ALL, TH1, 1'b0, C_HIT);
    pix(600, 400, 2'b01, H_ALL, TH1, 1'b0, C_HIT);
    pix(50, 470, 2'b01, H_ALL, TH1, 1'b0, C_HIT);
    pix(200, 100, 2'b10, H_ALL, TH1, 1'b1, C_HIT);
    vs_edge();
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL frame1_done_pulse: got %b required 1", frame_done);
    end
    vectors++;
    if (prev_count !== {6'd1, 6'd4}) begin
      miscompares++;
      $display("FAIL frame1_prev_count: got ch1=%0d ch0=%0d required ch1=1 ch0=4", prev_count[11:6], prev_count[5:0]);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL frame1_done_single: got %b required 0", frame_done);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      corner_sel_ch = 1'b0;
      corner_sel    = 2'(k);
      #1;
      vectors++;
      if ({corner_x, corner_y} !== {ex[k], ey[k]}) begin
        miscompares++;
        $display("FAIL frame1_ch0_corner%0d: got (%0d,%0d) required (%0d,%0d)", k, corner_x, corner_y, ex[k], ey[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      corner_sel_ch = 1'b1;
      corner_sel    = 2'(k);
      #1;
      vectors++;
      if ({corner_x, corner_y} !== {10'd200, 10'd100}) begin
        miscompares++;
        $display("FAIL frame1_ch1_corner%0d: got (%0d,%0d) required (200,100)", k, corner_x, corner_y);
      end
    end
  endtask

  task automatic test_classify();
    pix(300, 5, 2'b01, H_ALL, TH1, 1'b0, C_TR);
    pix(301, 5, 2'b01, H_ALL, TH1, 1'b0, C_HIT);
    pix(10, 20, 2'b01, H_ALL, TH1, 1'b0, C_TL);
    pix(600, 400, 2'b01, H_ALL, TH1, 1'b0, C_BR);
    pix(50, 470, 2'b01, H_ALL, TH1, 1'b0, C_BL);
  endtask

  task automatic test_priority();
    pix(200, 100, 2'b10, H_ALL, TH1, 1'b1, C_TL);
    pix(10, 20, 2'b10, H_ALL, TH1, 1'b1, C_HIT);
    pix(200, 100, 2'b11, H_ALL, TH1, 1'b0, C_HIT);
  endtask

  task automatic test_history();
    pix(123, 45, 2'b01, {4'h0, 4'b0011}, {3'd1, 3'd2}, 1'b0, C_NONE);
    pix(77, 33, 2'b01, {4'h0, 4'b0111}, {3'd1, 3'd2}, 1'b0, C_HIT);
  endtask

  task automatic test_hold();
    idle(2);
    @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, we} !== 2'b00) begin
      miscompares++;
      $display("FAIL hold_valid: got valid=%b we=%b required 0 0", out_valid, we);
    end
    vectors++;
    if ({color_x, color_y, updated_color_history, out_class} !== {10'd77, 10'd33, 8'h0F, C_HIT}) begin
      miscompares++;
      $display("FAIL hold_payload: got x=%0d y=%0d hist=%h cls=%0d required x=77 y=33 hist=0f cls=5",
               color_x, color_y, updated_color_history, out_class);
    end
  endtask

  task automatic test_range_boundary();
    logic [9:0] ex [4];
    logic [9:0] ey [4];
    ex = '{10'd10, 10'd301, 10'd50, 10'd600};
    ey = '{10'd20, 10'd5, 10'd470, 10'd400};
    pix(640, 10, 2'b01, H_ALL, TH1, 1'b0, C_NONE);
    pix(5, 480, 2'b01, H_ALL, TH1, 1'b0, C_NONE);
    @(negedge clk);
    in_valid = 1'b0;
    VGA_VS   = 1'b1;
    pix(1, 1, 2'b01, H_ALL, TH1, 1'b0, C_HIT);
    idle(1);
    vectors++;
    if (frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL frame2_done_pulse: got %b required 1", frame_done);
    end
    vectors++;
    if (prev_count !== {6'd3, 6'd7}) begin
      miscompares++;
      $display("FAIL frame2_prev_count: got ch1=%0d ch0=%0d required ch1=3 ch0=7", prev_count[11:6], prev_count[5:0]);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL frame2_done_single: got %b required 0", frame_done);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      corner_sel_ch = 1'b0;
      corner_sel    = 2'(k);
      #1;
      vectors++;
      if ({corner_x, corner_y} !== {ex[k], ey[k]}) begin
        miscompares++;
        $display("FAIL frame2_ch0_corner%0d: got (%0d,%0d) required (%0d,%0d)", k, corner_x, corner_y, ex[k], ey[k]);
      end
    end
    @(negedge clk);
    corner_sel_ch = 1'b1;
    corner_sel    = 2'd0;
    #1;
    vectors++;
    if ({corner_x, corner_y} !== {10'd10, 10'd20}) begin
      miscompares++;
      $display("FAIL frame2_ch1_tl: got (%0d,%0d) required (10,20)", corner_x, corner_y);
    end
    corner_sel = 2'd3;
    #1;
    vectors++;
    if ({corner_x, corner_y} !== {10'd200, 10'd100}) begin
      miscompares++;
      $display("FAIL frame2_ch1_br: got (%0d,%0d) required (200,100)", corner_x, corner_y);
    end
  endtask

  task automatic test_saturate();
    repeat (70) pix(5, 5, 2'b01, H_ALL, TH1, 1'b0, C_HIT);
    vs_edge();
    vectors++;
    if (prev_count !== {6'd0, 6'd63}) begin
      miscompares++;
      $display("FAIL saturate_count: got ch1=%0d ch0=%0d required ch1=0 ch0=63", prev_count[11:6], prev_count[5:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    pix(100, 100, 2'b01, H_ALL, TH1, 1'b0, C_HIT);
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    corner_sel_ch = 1'b0;
    corner_sel    = 2'd1;
    #1;
    vectors++;
    if ({prev_count, corner_x, corner_y} !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_prev: got count=%h tr=(%0d,%0d) required 0 (0,0)", prev_count, corner_x, corner_y);
    end
    vs_edge();
    vectors++;
    if ({frame_done, prev_count} !== {1'b1, 12'd0}) begin
      miscompares++;
      $display("FAIL midreset_next_frame: got fd=%b count=%h required fd=1 count=0", frame_done, prev_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame();
    test_classify();
    test_priority();
    test_history();
    test_hold();
    test_range_boundary();
    test_saturate();
    test_reset_mid_frame();
    idle(2);
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending pixels required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
